// File: rtl/lift_pkg.sv
// Shared constants and types for the lift input path: lane/word geometry, buffer depth and
// credit sizing.
package lift_pkg;

    localparam int unsigned DW        = 30;
    localparam int unsigned LANES     = 8;
    localparam int unsigned WORDS_BUF = 7;
    localparam int unsigned NUM_BUF   = 2;

    localparam int unsigned WORD_W   = LANES * DW;
    localparam int unsigned ADDR_W   = $clog2(WORDS_BUF);
    localparam int unsigned CREDIT_W = $clog2(NUM_BUF + 1);

    typedef logic [DW-1:0]       coeff_t;
    typedef logic [WORD_W-1:0]   word_t;
    typedef logic [ADDR_W-1:0]   addr_t;
    typedef logic [CREDIT_W-1:0] credit_t;

    function automatic logic is_last_word(input addr_t addr);
        return addr == ADDR_W'(WORDS_BUF - 1);
    endfunction

endpackage

// File: rtl/lift_din_credit.sv
// Saturating credit counter tracking free buffer halves: reserve on burst start, release on
// buffer read-out, give-back on an aborted burst. Overflow raises a sticky error.
module lift_din_credit
    import lift_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                reserve,
    input  logic                release_credit,
    input  logic                give_back,
    output logic [CREDIT_W-1:0] credits,
    output logic                credit_err
);

    credit_t       credits_q, credits_d;
    logic          err_q, err_d;
    logic [CREDIT_W:0] sum;

    always_comb begin
        credits_d = credits_q;
        err_d     = err_q;
        // One extra bit so an overflowing release is visible before saturation
        sum = {1'b0, credits_q}
            + {{CREDIT_W{1'b0}}, release_credit}
            + {{CREDIT_W{1'b0}}, give_back}
            - {{CREDIT_W{1'b0}}, reserve};
        if (sum > (CREDIT_W + 1)'(NUM_BUF)) begin
            credits_d = CREDIT_W'(NUM_BUF);
            err_d     = 1'b1;
        end else begin
            credits_d = sum[CREDIT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credits_q <= CREDIT_W'(NUM_BUF);
            err_q     <= 1'b0;
        end else begin
            credits_q <= credits_d;
            err_q     <= err_d;
        end
    end

    assign credits    = credits_q;
    assign credit_err = err_q;

endmodule

// File: rtl/lift_din_writer.sv
// Lift double-buffer feeder: bursts of WORDS_BUF words per buffer half, credit-gated input.
// Optional input skid register enabled by defining LIFT_DIN_SKID_EN.
module lift_din_writer
    import lift_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [WORD_W-1:0]   in_data,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                flush,
    output logic [ADDR_W-1:0]   wt_addr,
    output logic [WORD_W-1:0]   din,
    output logic                we,
    output logic                write_done,
    input  logic                last_read_of_buffer,
    output logic [CREDIT_W-1:0] credits,
    output logic                credit_err
);

    addr_t cnt_q, cnt_d;
    addr_t wt_addr_q;
    word_t din_q;
    logic  we_q, write_done_q;

    logic  can_take;
    logic  take;
    word_t take_data;
    logic  reserve, give_back;

    // Mid-burst words already own a half; a new burst needs a free one
    assign can_take = !flush && ((cnt_q != '0) || (credits != '0));

`ifdef LIFT_DIN_SKID_EN
    logic  skid_valid_q, skid_valid_d;
    word_t skid_data_q, skid_data_d;
    logic  ready_q, ready_d;
    logic  in_acc;

    assign in_ready = ready_q;
    assign in_acc   = in_valid && ready_q;

    always_comb begin
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        take         = 1'b0;
        take_data    = in_data;
        if (skid_valid_q) begin
            take      = can_take;
            take_data = skid_data_q;
            if (take || flush) begin
                skid_valid_d = 1'b0;
            end
        end else begin
            take = in_acc && can_take;
        end
        // Park an accepted word that is not written straight through
        if (in_acc && !(take && !skid_valid_q)) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
        end
        ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            ready_q      <= 1'b0;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            ready_q      <= ready_d;
        end
    end
`else
    assign in_ready  = rst_n && can_take;
    assign take      = in_valid && in_ready;
    assign take_data = in_data;
`endif

    assign reserve   = take && (cnt_q == '0);
    assign give_back = flush && (cnt_q != '0);

    always_comb begin
        cnt_d = cnt_q;
        if (take) begin
            cnt_d = is_last_word(cnt_q) ? '0 : cnt_q + 1'b1;
        end else if (flush) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            wt_addr_q    <= '0;
            din_q        <= '0;
            we_q         <= 1'b0;
            write_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            we_q         <= take;
            write_done_q <= take && is_last_word(cnt_q);
            if (take) begin
                wt_addr_q <= cnt_q;
                din_q     <= take_data;
            end
        end
    end

    lift_din_credit u_credit (
        .clk            (clk),
        .rst_n          (rst_n),
        .reserve        (reserve),
        .release_credit (last_read_of_buffer),
        .give_back      (give_back),
        .credits        (credits),
        .credit_err     (credit_err)
    );

    assign wt_addr    = wt_addr_q;
    assign din        = din_q;
    assign we         = we_q;
    assign write_done = write_done_q;

endmodule

// File: tb/tb_lift_din_writer.sv
// Directed-sequence bench with random data, checked against a transaction-level model of the
// burst writer (word count, credit pool, expected write beats).
module tb_lift_din_writer;
    import lift_pkg::*;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [WORD_W-1:0]   in_data;
    logic                in_valid;
    logic                in_ready;
    logic                flush;
    logic [ADDR_W-1:0]   wt_addr;
    logic [WORD_W-1:0]   din;
    logic                we;
    logic                write_done;
    logic                last_read_of_buffer;
    logic [CREDIT_W-1:0] credits;
    logic                credit_err;

    lift_din_writer dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .in_data             (in_data),
        .in_valid            (in_valid),
        .in_ready            (in_ready),
        .flush               (flush),
        .wt_addr             (wt_addr),
        .din                 (din),
        .we                  (we),
        .write_done          (write_done),
        .last_read_of_buffer (last_read_of_buffer),
        .credits             (credits),
        .credit_err          (credit_err)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    int                m_pos;    // words already written into the current half
    int                m_free;   // free buffer halves
    logic              m_err;
    logic              e_we, e_done;
    logic [WORD_W-1:0] e_din;
    int                e_addr;
    int                n_acc;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WORD_W-1:0] rand_word();
        logic [WORD_W-1:0] w;
        for (int k = 0; k < int'(LANES); k++) begin
            w[k*DW +: DW] = DW'($urandom);
        end
        return w;
    endfunction

    task automatic model_reset();
        m_pos  = 0;
        m_free = NUM_BUF;
        m_err  = 1'b0;
        e_we   = 1'b0;
        e_done = 1'b0;
        e_din  = '0;
        e_addr = 0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ":we"}, 256'(we), 256'(e_we));
        chk({tag, ":wt_addr"}, 256'(wt_addr), 256'(e_addr));
        chk({tag, ":write_done"}, 256'(write_done), 256'(e_done));
        if (e_we) chk({tag, ":din"}, 256'(din), 256'(e_din));
        chk({tag, ":credits"}, 256'(credits), 256'(m_free));
        chk({tag, ":credit_err"}, 256'(credit_err), 256'(m_err));
    endtask

    // One clock: drive, check readiness mid-cycle, advance model, check registered outputs
    task automatic step(input string tag, input logic v, input logic f, input logic r);
        logic exp_rdy, acc;
        int   nxt;
        in_valid            = v;
        flush               = f;
        last_read_of_buffer = r;
        in_data             = rand_word();
        #3;
        exp_rdy = !f && (m_pos != 0 || m_free != 0);
        chk({tag, ":in_ready"}, 256'(in_ready), 256'(exp_rdy));
        acc = v && exp_rdy;
        @(posedge clk);
        #1;
        e_we   = acc;
        e_done = acc && (m_pos == int'(WORDS_BUF) - 1);
        if (acc) begin
            e_din  = in_data;
            e_addr = m_pos;
        end
        nxt = m_free + (r ? 1 : 0) + ((f && m_pos != 0) ? 1 : 0)
            - ((acc && m_pos == 0) ? 1 : 0);
        if (nxt > int'(NUM_BUF)) begin
            nxt   = NUM_BUF;
            m_err = 1'b1;
        end
        m_free = nxt;
        if (acc) m_pos = (m_pos + 1) % int'(WORDS_BUF);
        else if (f) m_pos = 0;
        if (acc) n_acc++;
        check_outputs(tag);
        in_valid            = 1'b0;
        flush               = 1'b0;
        last_read_of_buffer = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, ":we"}, 256'(we), 256'(0));
        chk({tag, ":wt_addr"}, 256'(wt_addr), 256'(0));
        chk({tag, ":din"}, 256'(din), 256'(0));
        chk({tag, ":write_done"}, 256'(write_done), 256'(0));
        chk({tag, ":credits"}, 256'(credits), 256'(NUM_BUF));
        chk({tag, ":credit_err"}, 256'(credit_err), 256'(0));
        chk({tag, ":in_ready"}, 256'(in_ready), 256'(0));
    endtask

    initial begin
        int guard;
        rst_n               = 1'b0;
        in_valid            = 1'b0;
        flush               = 1'b0;
        last_read_of_buffer = 1'b0;
        in_data             = '0;
        model_reset();
        n_acc = 0;
        #12;
        check_reset_state("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: seven back-to-back words fill half 0
        for (int i = 0; i < 7; i++) step("t1_burst", 1'b1, 1'b0, 1'b0);
        chk("t1_credits_after_burst", 256'(credits), 256'(1));
        step("t1_release", 1'b0, 1'b0, 1'b1);

        // 2: 21 words with bubbles; both halves fill, then one release opens the third burst
        n_acc = 0;
        guard = 0;
        while (n_acc < 14 && guard < 60) begin
            step("t2_fill", 1'($urandom_range(0, 3) != 0), 1'b0, 1'b0);
            guard++;
        end
        chk("t2_fill_bound", 256'(n_acc), 256'(14));
        chk("t2_credits_empty", 256'(credits), 256'(0));
        step("t2_stall", 1'b1, 1'b0, 1'b0);
        step("t2_stall", 1'b1, 1'b0, 1'b0);
        step("t2_release", 1'b1, 1'b0, 1'b1);
        guard = 0;
        while (n_acc < 21 && guard < 60) begin
            step("t2_third", 1'($urandom_range(0, 3) != 0), 1'b0, 1'b0);
            guard++;
        end
        chk("t2_total_bound", 256'(n_acc), 256'(21));
        chk("t2_last_done", 256'(write_done), 256'(1));

        // 3: reserve and release together at one credit
        step("t3_prep_release", 1'b0, 1'b0, 1'b1);
        step("t3_both", 1'b1, 1'b0, 1'b1);
        chk("t3_credits_net0", 256'(credits), 256'(1));
        for (int i = 0; i < 6; i++) step("t3_rest", 1'b1, 1'b0, 1'b0);
        step("t3_release", 1'b0, 1'b0, 1'b1);

        // 4: partial burst then flush returns the credit and restarts at address 0
        for (int i = 0; i < 3; i++) step("t4_part", 1'b1, 1'b0, 1'b0);
        step("t4_flush", 1'b1, 1'b1, 1'b0);
        chk("t4_credits_back", 256'(credits), 256'(2));
        step("t4_flush_idle", 1'b0, 1'b1, 1'b0);
        step("t4_restart", 1'b1, 1'b0, 1'b0);
        chk("t4_restart_addr", 256'(wt_addr), 256'(0));
        for (int i = 0; i < 6; i++) step("t4_rest", 1'b1, 1'b0, 1'b0);
        step("t4_release", 1'b0, 1'b0, 1'b1);

        // 5: release with every half already free
        step("t5_overflow", 1'b0, 1'b0, 1'b1);
        chk("t5_err_set", 256'(credit_err), 256'(1));
        for (int i = 0; i < 3; i++) step("t5_sticky", 1'b1, 1'b0, 1'b0);

        // 6: asynchronous reset in the middle of a burst
        step("t6_word", 1'b1, 1'b0, 1'b0);
        in_valid = 1'b1;
        in_data  = rand_word();
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("t6_async_reset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 7; i++) step("t6_after", 1'b1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
